// File: rtl/enum_typedefs_pkg.sv
// Shared typedefs for the FP arithmetic blocks (multiplier and divider).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package enum_typedefs_pkg;

    // Rounding-mode encoding shared by every FP unit behind the dispatcher.
    // Codes 6 and 7 are not named and fall back to round-to-nearest-even.
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away      = 3'd5
    } round_t;

    // Sequencer states of the shift-add multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit positions inside the 8-bit status word (bit 6 is reserved, always 0).
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;
    localparam int ST_DIVZ    = 7;

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result bundle of the sequential FP multiplier.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface fp_mul_seq_if #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
);
    localparam int W = sig_width + ex_width + 1;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   round;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] z;
    logic [7:0]   status;
    logic         out_valid;
    logic         out_ready;

    // Requester side: issues operands, consumes results.
    modport master (
        output a, b, round, in_valid, out_ready,
        input  in_ready, z, status, out_valid
    );

    // Multiplier side.
    modport slave (
        input  a, b, round, in_valid, out_ready,
        output in_ready, z, status, out_valid
    );

endinterface

// File: rtl/fp_mul_round.sv
// Rounds a normalised significand using guard/round/sticky and the rounding mode.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module fp_mul_round
    import enum_typedefs_pkg::*;
#(
    parameter int sig_width = 23
) (
    input  logic [sig_width:0] mant_in,
    input  logic               g,
    input  logic               r,
    input  logic               s,
    input  logic               sign,
    input  round_t             round,
    output logic [sig_width:0] mant_out,
    output logic               carry,
    output logic               inexact
);

    logic inc;

    // Decide whether to bump the significand by one ulp, then add it in.
    always_comb begin
        inexact = g | r | s;
        inc     = 1'b0;
        case (round)
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = inexact & ~sign;
            IEEE_ninf: inc = inexact & sign;
            near_up:   inc = g;
            away:      inc = inexact;
            default:   inc = g & (r | s | mant_in[0]);
        endcase
        {carry, mant_out} = {1'b0, mant_in} + {{(sig_width + 1){1'b0}}, inc};
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP multiplier z = a*b, radix-2 shift-add significand product.
// Latency: fixed sig_width+2 cycles from accept to out_valid; initiation interval sig_width+4.
// Backpressure: accepts only in IDLE; result held in DONE until out_ready.
module fp_mul_seq
    import enum_typedefs_pkg::*;
#(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic         clk,
    input  logic         resetn,
    fp_mul_seq_if.slave  bus
);

    localparam int W  = sig_width + ex_width + 1;
    localparam int M  = sig_width + 1;
    localparam int EW = ex_width + 2;
    localparam int CW = $clog2(M + 1);
    localparam logic [EW-1:0] BIAS  = EW'(2 ** (ex_width - 1) - 1);
    localparam logic [EW-1:0] E_MAX = EW'(2 ** ex_width - 1);

    state_t         state_q, state_d;
    logic           load_op, mul_step, rnd_en;

    logic [W-1:0]   a_q, b_q;
    round_t         rnd_q;
    logic [M-1:0]   mcand_q, mplr_q;
    logic [2*M-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   z_q;
    logic [7:0]     status_q;

    logic [M:0]     add_sum;

    // Operand fields of the latched request.
    logic                sa, sb, sign;
    logic [ex_width-1:0] ea, eb;
    logic [sig_width-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan;

    // Normalisation / rounding intermediates.
    logic           norm;
    logic [M-1:0]   mant_n, mant_r;
    logic           g_b, r_b, s_b;
    logic           carry, inexact;
    logic [EW-1:0]  e_pre, e_fin;
    logic           ovf, unf, ovf_to_inf;
    logic           unused_mant_msb;

    logic [W-1:0]   z_d;
    logic [7:0]     status_d;

    // State register; an async reset drops any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d       = state_q;
        load_op       = 1'b0;
        mul_step      = 1'b0;
        rnd_en        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_op = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (cnt_q == CW'(sig_width)) state_d = RND;
            end
            RND: begin
                rnd_en  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Add the multiplicand into the upper half when the multiplier LSB is set.
    assign add_sum = {1'b0, acc_q[2*M-1:M]} + {1'b0, (mplr_q[0] ? mcand_q : {M{1'b0}})};

    // Operand capture, shift-add iteration and result registration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= IEEE_near;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            status_q <= '0;
        end else begin
            if (load_op) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                rnd_q   <= round_t'(bus.round);
                // Exponent field 0 flushes the hidden bit: denormals become zero.
                mcand_q <= {|bus.a[W-2:sig_width], bus.a[sig_width-1:0]};
                mplr_q  <= {|bus.b[W-2:sig_width], bus.b[sig_width-1:0]};
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (mul_step) begin
                acc_q  <= {add_sum, acc_q[M-1:1]};
                mplr_q <= mplr_q >> 1;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (rnd_en) begin
                z_q      <= z_d;
                status_q <= status_d;
            end
        end
    end

    assign bus.z      = z_q;
    assign bus.status = status_q;

    assign sa = a_q[W-1];
    assign sb = b_q[W-1];
    assign ea = a_q[W-2:sig_width];
    assign eb = b_q[W-2:sig_width];
    assign fa = a_q[sig_width-1:0];
    assign fb = b_q[sig_width-1:0];
    assign sign = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign is_nan = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);

    // Product lies in [1,4): pick the window below the leading one.
    assign norm   = acc_q[2*M-1];
    assign mant_n = norm ? acc_q[2*M-1:M] : acc_q[2*M-2:M-1];
    assign g_b    = norm ? acc_q[M-1] : acc_q[M-2];
    assign r_b    = norm ? acc_q[M-2] : acc_q[M-3];
    assign s_b    = norm ? (|acc_q[M-3:0]) : (|acc_q[M-4:0]);

    fp_mul_round #(
        .sig_width (sig_width)
    ) u_round (
        .mant_in  (mant_n),
        .g        (g_b),
        .r        (r_b),
        .s        (s_b),
        .sign     (sign),
        .round    (rnd_q),
        .mant_out (mant_r),
        .carry    (carry),
        .inexact  (inexact)
    );

    // On a rounding carry the significand wraps to 1.000..., so the stored
    // fraction is already zero; only the exponent needs the extra increment.
    assign unused_mant_msb = mant_r[M-1];

    assign e_pre = {2'b00, ea} + {2'b00, eb} - BIAS + EW'(norm);
    assign e_fin = e_pre + EW'(carry);
    assign ovf   = ~e_fin[EW-1] & (e_fin >= E_MAX);
    assign unf   = e_fin[EW-1] | (e_fin == '0);

    // Overflow saturates to infinity unless the mode rounds toward zero for this sign.
    always_comb begin
        case (rnd_q)
            IEEE_zero: ovf_to_inf = 1'b0;
            IEEE_pinf: ovf_to_inf = ~sign;
            IEEE_ninf: ovf_to_inf = sign;
            default:   ovf_to_inf = 1'b1;
        endcase
    end

    // Exception priority: NaN, infinity, zero, overflow, underflow, normal.
    always_comb begin
        z_d      = '0;
        status_d = '0;
        if (is_nan) begin
            z_d              = {1'b0, {ex_width{1'b1}}, 1'b1, {(sig_width - 1){1'b0}}};
            status_d[ST_NAN] = 1'b1;
        end else if (a_inf | b_inf) begin
            z_d              = {sign, {ex_width{1'b1}}, {sig_width{1'b0}}};
            status_d[ST_INF] = 1'b1;
        end else if (a_zero | b_zero) begin
            z_d               = {sign, {(W - 1){1'b0}}};
            status_d[ST_ZERO] = 1'b1;
        end else if (ovf) begin
            status_d[ST_HUGE]    = 1'b1;
            status_d[ST_INEXACT] = 1'b1;
            if (ovf_to_inf) begin
                z_d              = {sign, {ex_width{1'b1}}, {sig_width{1'b0}}};
                status_d[ST_INF] = 1'b1;
            end else begin
                z_d = {sign, {(ex_width - 1){1'b1}}, 1'b0, {sig_width{1'b1}}};
            end
        end else if (unf) begin
            z_d                  = {sign, {(W - 1){1'b0}}};
            status_d[ST_TINY]    = 1'b1;
            status_d[ST_INEXACT] = 1'b1;
            status_d[ST_ZERO]    = 1'b1;
        end else begin
            z_d                  = {sign, e_fin[ex_width-1:0], mant_r[sig_width-1:0]};
            status_d[ST_INEXACT] = inexact;
        end
        status_d[ST_DIVZ] = 1'b0;
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: arithmetic, rounding, exceptions, handshake, reset.
// Latency: checks the fixed 25-cycle accept-to-out_valid delay.
// Backpressure: exercises a held DONE state with out_ready low.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    fp_mul_seq_if bus ();

    fp_mul_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Issue one operation from IDLE (called at a negedge), wait for the result,
    // then retire it with a one-cycle out_ready. lat = -1 when no result appears.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic [2:0] orm,
                          output logic [31:0] oz, output logic [7:0] ost, output int lat);
        bus.a        = oa;
        bus.b        = ob;
        bus.round    = orm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        oz  = bus.z;
        ost = bus.status;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.a         = '0;
        bus.b         = '0;
        bus.round     = 3'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        resetn        = 1'b1;
        #1 resetn     = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.z !== 32'h0) begin bad++; $display("FAIL reset_z: got %h want 00000000", bus.z); end
        total++; if (bus.status !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", bus.status); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] z; logic [7:0] st; int lat;
        run_op(32'h40400000, 32'h40200000, 3'd0, z, st, lat);
        total++; if (lat !== 25) begin bad++; $display("FAIL basic_latency: got %0d want 25", lat); end
        total++; if (z !== 32'h40F00000) begin bad++; $display("FAIL basic_z: got %h want 40F00000", z); end
        total++; if (st !== 8'h00) begin bad++; $display("FAIL basic_status: got %h want 00", st); end
    endtask

    task automatic test_rounding;
        logic [31:0] z; logic [7:0] st; int lat;
        run_op(32'h3F800001, 32'h3F800001, 3'd0, z, st, lat);
        total++; if (z !== 32'h3F800002) begin bad++; $display("FAIL rnd_near_z: got %h want 3F800002", z); end
        total++; if (st !== 8'h20) begin bad++; $display("FAIL rnd_near_status: got %h want 20", st); end
        run_op(32'h3F800001, 32'h3F800001, 3'd2, z, st, lat);
        total++; if (z !== 32'h3F800003) begin bad++; $display("FAIL rnd_pinf_z: got %h want 3F800003", z); end
        total++; if (st !== 8'h20) begin bad++; $display("FAIL rnd_pinf_status: got %h want 20", st); end
        run_op(32'hBF800001, 32'h3F800001, 3'd3, z, st, lat);
        total++; if (z !== 32'hBF800003) begin bad++; $display("FAIL rnd_ninf_z: got %h want BF800003", z); end
        run_op(32'hBF800001, 32'h3F800001, 3'd2, z, st, lat);
        total++; if (z !== 32'hBF800002) begin bad++; $display("FAIL rnd_pinf_neg_z: got %h want BF800002", z); end
    endtask

    task automatic test_overflow;
        logic [31:0] z; logic [7:0] st; int lat;
        run_op(32'h7F000000, 32'h40000000, 3'd0, z, st, lat);
        total++; if (z !== 32'h7F800000) begin bad++; $display("FAIL ovf_near_z: got %h want 7F800000", z); end
        total++; if (st !== 8'h32) begin bad++; $display("FAIL ovf_near_status: got %h want 32", st); end
        run_op(32'h7F000000, 32'h40000000, 3'd1, z, st, lat);
        total++; if (z !== 32'h7F7FFFFF) begin bad++; $display("FAIL ovf_zero_z: got %h want 7F7FFFFF", z); end
        total++; if (st !== 8'h30) begin bad++; $display("FAIL ovf_zero_status: got %h want 30", st); end
    endtask

    task automatic test_underflow;
        logic [31:0] z; logic [7:0] st; int lat;
        run_op(32'h00800000, 32'h3F000000, 3'd0, z, st, lat);
        total++; if (z !== 32'h00000000) begin bad++; $display("FAIL unf_z: got %h want 00000000", z); end
        total++; if (st !== 8'h29) begin bad++; $display("FAIL unf_status: got %h want 29", st); end
    endtask

    task automatic test_specials;
        logic [31:0] z; logic [7:0] st; int lat;
        run_op(32'h7F800000, 32'h00000000, 3'd0, z, st, lat);
        total++; if (z !== 32'h7FC00000) begin bad++; $display("FAIL nan_z: got %h want 7FC00000", z); end
        total++; if (st !== 8'h04) begin bad++; $display("FAIL nan_status: got %h want 04", st); end
        total++; if (lat !== 25) begin bad++; $display("FAIL nan_latency: got %0d want 25", lat); end
        run_op(32'hFF800000, 32'h40000000, 3'd0, z, st, lat);
        total++; if (z !== 32'hFF800000) begin bad++; $display("FAIL inf_z: got %h want FF800000", z); end
        total++; if (st !== 8'h02) begin bad++; $display("FAIL inf_status: got %h want 02", st); end
        run_op(32'h80000000, 32'h40000000, 3'd0, z, st, lat);
        total++; if (z !== 32'h80000000) begin bad++; $display("FAIL zero_z: got %h want 80000000", z); end
        total++; if (st !== 8'h01) begin bad++; $display("FAIL zero_status: got %h want 01", st); end
    endtask

    task automatic test_backpressure;
        int lat;
        int seen;
        bus.a        = 32'h40400000;
        bus.b        = 32'h40200000;
        bus.round    = 3'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++; if (lat !== 25) begin bad++; $display("FAIL bp_latency: got %0d want 25", lat); end
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (bus.z !== 32'h40F00000) begin bad++; $display("FAIL bp_hold_z: cycle %0d got %h want 40F00000", c, bus.z); end
            total++; if (bus.status !== 8'h00) begin bad++; $display("FAIL bp_hold_status: cycle %0d got %h want 00", c, bus.status); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready: cycle %0d got %b want 0", c, bus.in_ready); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_out_valid: cycle %0d got %b want 1", c, bus.out_valid); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL bp_no_ghost_op: got %0d result cycles want 0", seen); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] z; logic [7:0] st; int lat; int seen;
        bus.a        = 32'h40400000;
        bus.b        = 32'h40200000;
        bus.round    = 3'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_partial: got %0d result cycles want 0", seen); end
        run_op(32'h3FC00000, 32'h3FC00000, 3'd0, z, st, lat);
        total++; if (z !== 32'h40100000) begin bad++; $display("FAIL midrst_next_z: got %h want 40100000", z); end
        total++; if (st !== 8'h00) begin bad++; $display("FAIL midrst_next_status: got %h want 00", st); end
        total++; if (lat !== 25) begin bad++; $display("FAIL midrst_next_latency: got %0d want 25", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_underflow();
        test_specials();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
